// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_arbiter_if : requester and uart_tx handshake bundle         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [IDX_W-1:0]     owner;
  logic                 owner_valid;

  // master is the arbiter; slave is the requester/uart_tx side
  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, owner, owner_valid
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data, owner, owner_valid
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin, message-locked sharing of one uart_tx|
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_LOAD      = 3'd2,
    S_START     = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_WAIT_DONE = 3'd5
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic               owner_valid_q;
  logic               tx_start_q;
  logic [7:0]         tx_data_q;
  logic               last_q;
  logic [1:0]         to_cnt_q;

  logic [IDX_W-1:0]   arb_idx_d;
  logic               arb_found_d;
  logic [IDX_W-1:0]   rr_next_d;
  logic               load_go_d;
  logic               byte_done_d;
  logic [NUM_REQ-1:0] req_ready_d;

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin : p_arb
    int j;
    j           = 0;
    arb_found_d = 1'b0;
    arb_idx_d   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (bus.req_valid[IDX_W'(j)]) begin
        arb_found_d = 1'b1;
        arb_idx_d   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    rr_next_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
    load_go_d   = (state_q == S_LOAD) && !bus.tx_busy && bus.req_valid[owner_q];
    req_ready_d = '0;
    if (load_go_d) req_ready_d[owner_q] = 1'b1;
    // A byte is finished on tx_busy falling, or when uart_tx never acknowledged it.
    byte_done_d = !bus.tx_busy &&
                  (((state_q == S_WAIT_BUSY) && (to_cnt_q == 2'd3)) ||
                   (state_q == S_WAIT_DONE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      last_q        <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|bus.req_valid) state_q <= S_ARB;
        end
        S_ARB: begin
          if (arb_found_d) begin
            owner_q       <= arb_idx_d;
            owner_valid_q <= 1'b1;
            state_q       <= S_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (!bus.tx_busy) begin
            if (bus.req_valid[owner_q]) begin
              tx_data_q  <= bus.req_data[{owner_q, 3'b000} +: 8];
              last_q     <= bus.req_last[owner_q];
              tx_start_q <= 1'b1;
              state_q    <= S_START;
            end else begin
              owner_valid_q <= 1'b0;
              rr_ptr_q      <= rr_next_d;
              state_q       <= S_IDLE;
            end
          end
        end
        S_START: begin
          to_cnt_q <= '0;
          state_q  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus.tx_busy) state_q <= S_WAIT_DONE;
          else             to_cnt_q <= to_cnt_q + 2'd1;
        end
        S_WAIT_DONE: ;
        default: state_q <= S_IDLE;
      endcase

      if (byte_done_d) begin
        if (last_q) begin
          owner_valid_q <= 1'b0;
          rr_ptr_q      <= rr_next_d;
          state_q       <= S_IDLE;
        end else begin
          state_q <= S_LOAD;
        end
      end
    end
  end

  assign bus.req_ready   = req_ready_d;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.owner       = owner_q;
  assign bus.owner_valid = owner_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_tx_arbiter : scoreboard bench for NUM_REQ=2 and NUM_REQ=3   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(2)) bus2 ();
  uart_tx_arbiter_if #(.NUM_REQ(3)) bus3 ();

  uart_tx_arbiter #(.NUM_REQ(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));
  uart_tx_arbiter #(.NUM_REQ(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.master));

  // Requester slots 0..1 feed dut2, slots 2..4 feed dut3; entries are {last, data}.
  logic [8:0] pq [5][$];
  logic [4:0] p_valid;
  logic [4:0] p_last;
  logic [7:0] p_data [5];
  logic [4:0] rdy;

  assign bus2.req_valid = p_valid[1:0];
  assign bus2.req_last  = p_last[1:0];
  assign bus2.req_data  = {p_data[1], p_data[0]};
  assign bus3.req_valid = p_valid[4:2];
  assign bus3.req_last  = p_last[4:2];
  assign bus3.req_data  = {p_data[4], p_data[3], p_data[2]};
  assign rdy            = {bus3.req_ready, bus2.req_ready};

  // uart_tx models
  logic busy2 = 1'b0;
  logic busy3 = 1'b0;
  int   cnt2  = 0;
  int   cnt3  = 0;
  logic never_busy = 1'b0;

  always @(posedge clk) begin
    if (bus2.tx_start && !never_busy) begin
      busy2 <= 1'b1;
      cnt2  <= 9;
    end else if (busy2) begin
      if (cnt2 == 0) busy2 <= 1'b0;
      else           cnt2  <= cnt2 - 1;
    end
    if (bus3.tx_start) begin
      busy3 <= 1'b1;
      cnt3  <= 2;
    end else if (busy3) begin
      if (cnt3 == 0) busy3 <= 1'b0;
      else           cnt3  <= cnt3 - 1;
    end
  end

  assign bus2.tx_busy = busy2;
  assign bus3.tx_busy = busy3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [10:0] exp2 [$];
  logic [10:0] exp3 [$];
  int   start_cyc2 [$];
  int   pend2 = 0;
  logic arm2 = 1'b0;
  logic busy_prev2 = 1'b0;
  logic [7:0] rec2 = 8'h00;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Producer: hold each byte until its req_ready pulse, then advance.
  initial begin : producer
    logic [4:0] acc;
    p_valid = '0;
    p_last  = '0;
    for (int r = 0; r < 5; r++) p_data[r] = 8'h00;
    forever begin
      @(negedge clk);
      acc = p_valid & rdy;
      @(posedge clk);
      #1;
      for (int r = 0; r < 5; r++) begin
        if (acc[r] && pq[r].size() > 0) void'(pq[r].pop_front());
        if (pq[r].size() > 0) begin
          p_valid[r] = 1'b1;
          p_data[r]  = pq[r][0][7:0];
          p_last[r]  = pq[r][0][8];
        end else begin
          p_valid[r] = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every tx_start.
  initial begin : monitor
    logic [10:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend2 = 0;
        arm2  = 1'b0;
      end else begin
        if (bus2.req_ready != 2'b00) begin
          check("ready2_onehot", int'($onehot(bus2.req_ready)), 1);
          check("ready2_is_owner", int'(bus2.req_ready[bus2.owner]), 1);
          pend2++;
        end
        if (bus2.tx_start) begin
          check("start2_while_busy", int'(busy2), 0);
          check("start2_per_ready", pend2, 1);
          pend2 = 0;
          check("start2_owner_valid", int'(bus2.owner_valid), 1);
          if (exp2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL start2_unexpected: got tx_data 0x%0h, required no tx_start", bus2.tx_data);
          end else begin
            e = exp2.pop_front();
            check("tx_data2", int'(bus2.tx_data), int'(e[7:0]));
            check("owner2", int'(bus2.owner), int'(e[10:8]));
          end
          start_cyc2.push_back(cyc);
          arm2 = 1'b1;
          rec2 = bus2.tx_data;
        end
        if (arm2 && busy_prev2 && !busy2) begin
          check("tx_data2_stable", int'(bus2.tx_data), int'(rec2));
          arm2 = 1'b0;
        end
        if (bus3.tx_start) begin
          check("start3_while_busy", int'(busy3), 0);
          if (exp3.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL start3_unexpected: got tx_data 0x%0h, required no tx_start", bus3.tx_data);
          end else begin
            e = exp3.pop_front();
            check("tx_data3", int'(bus3.tx_data), int'(e[7:0]));
            check("owner3", int'(bus3.owner), int'(e[10:8]));
          end
        end
      end
      busy_prev2 = busy2;
    end
  end

  task automatic wait_idle2(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = (exp2.size() == 0) && (p_valid[1:0] == 2'b00) && !bus2.owner_valid && !busy2;
    end
    check(name, int'(ok), 1);
  endtask

  task automatic wait_idle3(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (exp3.size() == 0) && (p_valid[4:2] == 3'b000) && !bus3.owner_valid && !busy3;
    end
    check(name, int'(ok), 1);
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_tx_start"}, int'(bus2.tx_start), 0);
    check({tag, "_tx_data"}, int'(bus2.tx_data), 0);
    check({tag, "_req_ready"}, int'(bus2.req_ready), 0);
    check({tag, "_owner"}, int'(bus2.owner), 0);
    check({tag, "_owner_valid"}, int'(bus2.owner_valid), 0);
  endtask

  initial begin : stimulus
    bit ok;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_clear("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin from rr_ptr=0
    for (int i = 0; i < 4; i++) begin
      pq[0].push_back({1'b1, 8'h10});
      pq[1].push_back({1'b1, 8'h20});
      exp2.push_back({3'd0, 8'h10});
      exp2.push_back({3'd1, 8'h20});
    end
    wait_idle2("rr_done");

    // Single byte with latency check (rr_ptr back to 0)
    pq[0].push_back({1'b1, 8'h41});
    exp2.push_back({3'd0, 8'h41});
    @(negedge clk);
    @(negedge clk);
    check("lat_ready_early", int'(bus2.req_ready), 0);
    @(negedge clk);
    check("lat_ready", int'(bus2.req_ready), 1);
    @(negedge clk);
    check("lat_tx_start", int'(bus2.tx_start), 1);
    wait_idle2("single_done");

    // rr_ptr now 1: simultaneous requests grant req1 first
    pq[0].push_back({1'b1, 8'h51});
    pq[1].push_back({1'b1, 8'h62});
    exp2.push_back({3'd1, 8'h62});
    exp2.push_back({3'd0, 8'h51});
    wait_idle2("rrptr_done");

    // Message lock: req1 arrives after req0 owns the grant
    start_cyc2.delete();
    pq[0].push_back({1'b0, 8'hA1});
    pq[0].push_back({1'b0, 8'hA2});
    pq[0].push_back({1'b1, 8'hA3});
    exp2.push_back({3'd0, 8'hA1});
    exp2.push_back({3'd0, 8'hA2});
    exp2.push_back({3'd0, 8'hA3});
    exp2.push_back({3'd1, 8'hB1});
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus2.owner_valid;
    end
    check("lock_grant", int'(ok), 1);
    pq[1].push_back({1'b1, 8'hB1});
    wait_idle2("lock_done");
    check("lock_starts", start_cyc2.size(), 4);
    if (start_cyc2.size() == 4) begin
      check("gap_a1_a2", start_cyc2[1] - start_cyc2[0], 13);
      check("gap_a2_a3", start_cyc2[2] - start_cyc2[1], 13);
      check("gap_a3_b1", start_cyc2[3] - start_cyc2[2], 15);
    end

    // uart_tx that never raises busy: timeout after 4 cycles
    never_busy = 1'b1;
    start_cyc2.delete();
    pq[0].push_back({1'b0, 8'hE1});
    pq[0].push_back({1'b1, 8'hE2});
    exp2.push_back({3'd0, 8'hE1});
    exp2.push_back({3'd0, 8'hE2});
    wait_idle2("timeout_done");
    check("timeout_starts", start_cyc2.size(), 2);
    if (start_cyc2.size() == 2) check("gap_timeout", start_cyc2[1] - start_cyc2[0], 6);
    never_busy = 1'b0;

    // Reset during WAIT_DONE of byte 2 of 3
    start_cyc2.delete();
    pq[0].push_back({1'b0, 8'hC1});
    pq[0].push_back({1'b0, 8'hC2});
    pq[0].push_back({1'b1, 8'hC3});
    exp2.push_back({3'd0, 8'hC1});
    exp2.push_back({3'd0, 8'hC2});
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (start_cyc2.size() >= 2);
    end
    check("reset_second_start", int'(ok), 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_clear("midreset");
    pq[0].delete();
    @(negedge clk);
    pq[1].push_back({1'b1, 8'hD1});
    exp2.push_back({3'd1, 8'hD1});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus2.owner_valid;
    end
    check("after_reset_grant", int'(ok), 1);
    check("after_reset_owner", int'(bus2.owner), 1);
    wait_idle2("after_reset_done");

    // NUM_REQ=3: set rr_ptr=1, then requests from 2 and 0
    pq[2].push_back({1'b1, 8'h30});
    exp3.push_back({3'd0, 8'h30});
    wait_idle3("n3_first");
    pq[4].push_back({1'b1, 8'h32});
    pq[2].push_back({1'b1, 8'h31});
    exp3.push_back({3'd2, 8'h32});
    exp3.push_back({3'd0, 8'h31});
    wait_idle3("n3_order");
    // rr_ptr should be 1 again: req1 beats req0
    pq[2].push_back({1'b1, 8'h33});
    pq[3].push_back({1'b1, 8'h34});
    exp3.push_back({3'd1, 8'h34});
    exp3.push_back({3'd0, 8'h33});
    wait_idle3("n3_rrptr");

    check("exp2_drained", exp2.size(), 0);
    check("exp3_drained", exp3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between NUM_REQ byte producers, e.g. an echo path, a status reporter and a debug dump.
- Grants the transmitter round-robin and sequences the tx_start/tx_busy handshake.
- Keeps the grant for multi-byte messages until the requester marks the last byte, so messages from different requesters never interleave on TX.
- Sits between the requesters and uart_tx in the top-level design.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- IDX_W, $clog2(NUM_REQ): width of the owner index.

Ports:
- clk  input  1: system clock.
- rst_n  input  1: asynchronous active-low reset.
- req_valid  input  NUM_REQ: requester i has a byte pending. Requester i holds this high until it sees a req_ready pulse.
- req_data  input  8*NUM_REQ: byte of requester i on bits [8i+7:8i]. Held stable while req_valid[i] is high.
- req_last  input  NUM_REQ: the pending byte of requester i ends its message.
- req_ready  output  NUM_REQ: one-cycle pulse; requester i's byte has been accepted.
- tx_start  output  1: to uart_tx; one-cycle pulse.
- tx_data  output  8: to uart_tx; held stable from the tx_start cycle until tx_busy falls.
- tx_busy  input  1: from uart_tx.
- owner  output  IDX_W: index of the current grant holder.
- owner_valid  output  1: a grant is held.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; tx_start=0, tx_data=0, req_ready=0, owner=0, owner_valid=0, round-robin pointer rr_ptr=0.
- States: IDLE, ARB, LOAD, START, WAIT_BUSY, WAIT_DONE.
- IDLE: if any req_valid is high, go to ARB next cycle.
- ARB: pick the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ. Then set owner=i, owner_valid=1 and go to LOAD. If every req_valid has dropped, return to IDLE.
- LOAD, entered with owner's req_valid=1:
  - latch tx_data = owner's req_data and latch last_flag = owner's req_last;
  - pulse req_ready[owner] for exactly this cycle;
  - go to START.
- LOAD, entered with owner's req_valid=0: the requester abandoned the message. Clear owner_valid, set rr_ptr=owner+1 (mod NUM_REQ), go to IDLE.
- LOAD waits for tx_busy=0 before acting.
- START: tx_start=1 for exactly this one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE.
  - Timeout: if tx_busy is still 0 after 4 cycles, treat the byte as sent and go straight to the post-byte decision below.
- WAIT_DONE: on tx_busy=0, make the post-byte decision:
  - last_flag=1: clear owner_valid, set rr_ptr=owner+1 (mod NUM_REQ), go to IDLE.
  - last_flag=0: keep owner, go to LOAD. Other requesters are ignored while the grant is held.
- Latency: req_valid rising in IDLE, with the transmitter free, gives req_ready at cycle +2 and tx_start at cycle +3.
- Minimum spacing between tx_start pulses is byte time + 3 cycles.
- req_ready is never high for two requesters in the same cycle. It is never high outside LOAD.
- tx_data changes only in LOAD.
- Simultaneous requests are resolved purely by rr_ptr. No requester waits more than NUM_REQ-1 messages.
- The grant is never revoked mid-message. A requester that never asserts req_last holds TX indefinitely; this is the requester's responsibility.
- Reset asserted mid-byte: outputs clear immediately. uart_tx may finish its frame; on release the arbiter waits in LOAD until tx_busy=0.
- All index arithmetic wraps modulo NUM_REQ, so rr_ptr never holds an out-of-range value when NUM_REQ is not a power of two.

Test Plan:
- Single byte: NUM_REQ=2; req0 sends 0x41 with last=1 → one req_ready[0] pulse, one tx_start with tx_data=0x41, owner_valid=1 only between ARB and the fall of tx_busy, then rr_ptr=1.
- Round-robin: req0 and req1 both valid, single-byte messages, 0x10 and 0x20 repeated 4 times → tx_data sequence 0x10,0x20,0x10,0x20,0x10,0x20,0x10,0x20.
- Lock: req0 sends 3-byte message 0xA1,0xA2,0xA3 (last on 0xA3) while req1 holds 0xB1 → TX order A1,A2,A3,B1; req_ready[1] stays 0 until A3 completes.
- Handshake: uart_tx model with 10-cycle busy → tx_start never asserted while tx_busy=1; exactly one tx_start per req_ready; tx_data stable during busy. Separately, a model that never raises tx_busy → timeout after 4 cycles, next byte proceeds.
- Reset mid-message: rst_n pulled low during WAIT_DONE of byte 2 of 3 → all outputs 0 in the same cycle. After release with only req1 valid, owner=1 and its byte is sent first.
- NUM_REQ=3: requests from 2 then 0, with rr_ptr=1 → grant order 2,0; rr_ptr ends at 1.
